// File: rtl/control_fsm.sv
// control_fsm: multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT); define ILLEGAL_TRAP_EN to trap unknown opcodes
module control_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int RETIRE_W       = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                branch_taken,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                ir_we,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic                reg_we,
  output logic [1:0]          wb_sel,
  output logic                alu_src_imm,
  output logic                halted,
  output logic                bus_err,
  output logic                illegal,
  output logic [RETIRE_W-1:0] instret,
  output logic [2:0]          state_o
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
  state_t        state;
  logic [6:0]    op_q;
  logic [CW-1:0] wcnt;
  logic          legal, is_sys, q_ld, q_st, q_br, waiting, timeout;
  logic [1:0]    jump_sel, res_sel;
  assign state_o = state;
  assign legal   = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_REG};
  assign is_sys  = opcode == OP_SYS;
  assign q_ld    = op_q == OP_LD;
  assign q_st    = op_q == OP_ST;
  assign q_br    = op_q == OP_BR;
  assign jump_sel = op_q == OP_JAL ? 2'b01 : op_q == OP_JALR ? 2'b10 : 2'b00;
  assign res_sel  = q_ld ? 2'b01 : (op_q == OP_JAL || op_q == OP_JALR) ? 2'b10 : 2'b00;
  assign waiting = (state == FETCH && !imem_ack) || (state == MEM && !dmem_ack);
  assign timeout = TIMEOUT_CYCLES != 0 && waiting && wcnt == LIMIT;
  // strobes and selects decoded from the current state; everything is quiet while reset is high
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    pc_sel      = 2'b00;
    wb_sel      = 2'b00;
    alu_src_imm = !(op_q == OP_REG || op_q == OP_BR);
    if (!reset) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        DECODE: pc_we = !TRAP && !legal && !is_sys;
        EXEC: begin
          pc_we  = q_br;
          pc_sel = q_br ? {1'b0, branch_taken} : jump_sel;
          wb_sel = res_sel;
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = q_st;
          pc_we    = q_st && dmem_ack;
          pc_sel   = jump_sel;
          wb_sel   = res_sel;
        end
        WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          pc_sel = jump_sel;
          wb_sel = res_sel;
        end
        default: ;
      endcase
    end
  end
  // state sequencing, wait counter, retire counter and sticky status flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      op_q    <= '0;
      wcnt    <= '0;
      instret <= '0;
      halted  <= 1'b0;
      bus_err <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      wcnt <= waiting ? wcnt + CW'(1) : '0;
      if (pc_we) instret <= instret + RETIRE_W'(1);
      case (state)
        FETCH: state <= imem_ack ? DECODE : FETCH;
        DECODE: begin
          op_q   <= opcode;
          state  <= legal ? EXEC : (is_sys || TRAP) ? HALT : FETCH;
          halted <= halted | is_sys | (TRAP & !legal);
`ifdef ILLEGAL_TRAP_EN
          illegal <= illegal | (!legal && !is_sys);
`endif
        end
        EXEC:    state <= (q_ld || q_st) ? MEM : q_br ? FETCH : WB;
        MEM:     state <= dmem_ack ? (q_ld ? WB : FETCH) : MEM;
        WB:      state <= FETCH;
        default: state <= HALT;
      endcase
      if (timeout) begin
        state   <= HALT;
        halted  <= 1'b1;
        bus_err <= 1'b1;
      end
    end
  end
`ifndef ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: per-instruction cycle-plan model of the sequencer, checked every cycle, plus randomized traffic
module tb_control_fsm;
  localparam int T = 16;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BR = 7'b1100011, LD = 7'b0000011, ST = 7'b0100011, IMM = 7'b0010011;
  localparam logic [6:0] REG = 7'b0110011, SYS = 7'b1110011;
  logic clock = 1'b0, reset = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [6:0] opcode = '0;
  logic imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, alu_src_imm, halted, bus_err, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [31:0] instret;
  logic [2:0] state_o;
  control_fsm #(.TIMEOUT_CYCLES(T), .RETIRE_W(32)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .ir_we(ir_we),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .halted(halted),
    .bus_err(bus_err), .illegal(illegal), .instret(instret), .state_o(state_o)
  );
  always #5 clock = ~clock;
  typedef struct packed {
    logic [2:0]  st;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, chk_sel;
    logic [1:0]  pc_sel, wb_sel;
    logic        alu_imm, halted, bus_err, illegal;
    logic [31:0] instret;
  } exp_t;
  exp_t ex;
  logic ex_valid = 1'b0;
  int vectors = 0, miscompares = 0, dreq_cnt = 0, regwe_cnt = 0;
  string lit_n [256];
  logic [31:0] lit_a [256], lit_x [256];
  int lit_wr = 0, lit_rd = 0;
  logic [31:0] m_instret = '0;
  logic m_halted = 1'b0, m_bus_err = 1'b0, m_illegal = 1'b0;
  task automatic note(input string n, input logic [31:0] a, input logic [31:0] x);
    vectors++;
    if (a !== x) begin
      miscompares++;
      $display("FAIL %s t=%0t got %0h want %0h", n, $time, a, x);
    end
  endtask
  always @(negedge clock) begin
    if (ex_valid) begin
      note("state_o", 32'(state_o), 32'(ex.st));
      note("imem_req", 32'(imem_req), 32'(ex.imem_req));
      note("ir_we", 32'(ir_we), 32'(ex.ir_we));
      note("dmem_req", 32'(dmem_req), 32'(ex.dmem_req));
      if (ex.dmem_req) note("dmem_we", 32'(dmem_we), 32'(ex.dmem_we));
      note("pc_we", 32'(pc_we), 32'(ex.pc_we));
      note("reg_we", 32'(reg_we), 32'(ex.reg_we));
      if (ex.chk_sel || ex.pc_we) note("pc_sel", 32'(pc_sel), 32'(ex.pc_sel));
      if (ex.chk_sel) begin
        note("wb_sel", 32'(wb_sel), 32'(ex.wb_sel));
        note("alu_src_imm", 32'(alu_src_imm), 32'(ex.alu_imm));
      end
      note("halted", 32'(halted), 32'(ex.halted));
      note("bus_err", 32'(bus_err), 32'(ex.bus_err));
      note("illegal", 32'(illegal), 32'(ex.illegal));
      note("instret", instret, ex.instret);
      dreq_cnt  += 32'(dmem_req);
      regwe_cnt += 32'(reg_we);
    end
    while (lit_rd < lit_wr) begin
      note(lit_n[lit_rd], lit_a[lit_rd], lit_x[lit_rd]);
      lit_rd++;
    end
  end
  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] x);
    lit_n[lit_wr] = n;
    lit_a[lit_wr] = a;
    lit_x[lit_wr] = x;
    lit_wr++;
  endtask
  function automatic exp_t base(input logic [2:0] st);
    exp_t e = '0;
    e.st      = st;
    e.halted  = m_halted;
    e.bus_err = m_bus_err;
    e.illegal = m_illegal;
    e.instret = m_instret;
    return e;
  endfunction
  function automatic exp_t sel(input exp_t ei, input logic [6:0] op, input logic taken);
    exp_t e = ei;
    e.chk_sel = 1'b1;
    e.pc_sel  = op == BR ? {1'b0, taken} : op == JAL ? 2'b01 : op == JALR ? 2'b10 : 2'b00;
    e.wb_sel  = op == LD ? 2'b01 : (op == JAL || op == JALR) ? 2'b10 : 2'b00;
    e.alu_imm = !(op == REG || op == BR);
    return e;
  endfunction
  task automatic tick(input exp_t e, input logic ia, input logic da, input logic bt, input logic [6:0] op);
    imem_ack = ia;
    dmem_ack = da;
    branch_taken = bt;
    opcode = op;
    ex = e;
    ex_valid = 1'b1;
    @(posedge clock);
    #1;
  endtask
  task automatic clear_model();
    m_instret = '0;
    m_halted = 1'b0;
    m_bus_err = 1'b0;
    m_illegal = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    tick(base(3'd0), 1'b1, 1'b1, 1'b1, 7'($urandom));
    tick(base(3'd0), 1'b1, 1'b1, 1'b1, 7'($urandom));
    reset = 1'b0;
  endtask
  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) tick(base(3'd5), 1'($urandom), 1'($urandom), 1'($urandom), 7'($urandom));
  endtask
  // one instruction: fetch waits fd cycles, memory waits md cycles; abort asserts reset in the 2nd MEM cycle
  task automatic run_instr(input logic [6:0] op, input int fd, input int md, input logic taken,
                           input bit abort, output int ncyc);
    exp_t e;
    bit known, mem, ack;
    ncyc = 0;
    known = op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, IMM, REG};
    mem = op == LD || op == ST;
    for (int k = 0; k < T; k++) begin
      ack = k == fd;
      e = base(3'd0);
      e.imem_req = 1'b1;
      e.ir_we = ack;
      tick(e, ack, 1'($urandom), 1'($urandom), 7'($urandom));
      ncyc++;
      if (ack) break;
      if (k == T - 1) begin
        m_halted = 1'b1;
        m_bus_err = 1'b1;
        return;
      end
    end
    e = base(3'd1);
    e.pc_we = !known && op != SYS && !TRAP;
    tick(e, 1'($urandom), 1'($urandom), 1'($urandom), op);
    ncyc++;
    if (op == SYS) begin
      m_halted = 1'b1;
      return;
    end
    if (!known) begin
      if (TRAP) begin
        m_halted = 1'b1;
        m_illegal = 1'b1;
      end else m_instret++;
      return;
    end
    e = sel(base(3'd2), op, taken);
    e.pc_we = op == BR;
    tick(e, 1'($urandom), 1'($urandom), taken, op);
    ncyc++;
    if (op == BR) begin
      m_instret++;
      return;
    end
    if (mem) begin
      for (int k = 0; k < T; k++) begin
        if (abort && k == 1) begin
          reset = 1'b1;
          clear_model();
          tick(base(3'd0), 1'b1, 1'b1, 1'b1, op);
          reset = 1'b0;
          ncyc++;
          return;
        end
        ack = k == md;
        e = sel(base(3'd3), op, 1'b0);
        e.dmem_req = 1'b1;
        e.dmem_we = op == ST;
        e.pc_we = op == ST && ack;
        tick(e, 1'($urandom), ack, 1'($urandom), op);
        ncyc++;
        if (ack) break;
        if (k == T - 1) begin
          m_halted = 1'b1;
          m_bus_err = 1'b1;
          return;
        end
      end
      if (op == ST) begin
        m_instret++;
        return;
      end
    end
    e = sel(base(3'd4), op, 1'b0);
    e.reg_we = 1'b1;
    e.pc_we = 1'b1;
    tick(e, 1'($urandom), 1'($urandom), 1'($urandom), op);
    ncyc++;
    m_instret++;
  endtask
  function automatic logic [6:0] pick();
    case ($urandom_range(0, 13))
      0: return LUI;
      1: return AUIPC;
      2: return JAL;
      3: return JALR;
      4, 5: return BR;
      6, 7: return LD;
      8, 9: return ST;
      10: return IMM;
      11: return REG;
      12: return ($urandom_range(0, 1) == 0) ? SYS : 7'b0001111;
      default: return 7'b0000000;
    endcase
  endfunction
  function automatic int delay();
    return $urandom_range(0, 9) < 8 ? int'($urandom_range(0, 3)) : int'($urandom_range(T - 2, T + 1));
  endfunction
  initial begin
    int n, r0, r1;
    do_reset();
    run_instr(IMM, 0, 0, 1'b0, 1'b0, n);
    lit("addi_cycles", 32'(n), 32'd4);
    lit("addi_instret", instret, 32'd1);
    r0 = dreq_cnt;
    run_instr(LD, 0, 3, 1'b0, 1'b0, n);
    lit("lw_cycles", 32'(n), 32'd8);
    lit("lw_dmem_req_cycles", 32'(dreq_cnt - r0), 32'd4);
    r1 = regwe_cnt;
    run_instr(BR, 0, 0, 1'b1, 1'b0, n);
    lit("beq_taken_cycles", 32'(n), 32'd3);
    run_instr(BR, 1, 0, 1'b0, 1'b0, n);
    lit("beq_not_taken_cycles", 32'(n), 32'd4);
    lit("beq_reg_we_count", 32'(regwe_cnt - r1), 32'd0);
    run_instr(JALR, 0, 0, 1'b0, 1'b0, n);
    lit("jalr_cycles", 32'(n), 32'd4);
    run_instr(ST, 0, 0, 1'b0, 1'b0, n);
    lit("sw_cycles", 32'(n), 32'd4);
    lit("sw_instret", instret, 32'd6);
    run_instr(SYS, 0, 0, 1'b0, 1'b0, n);
    lit("ecall_cycles", 32'(n), 32'd2);
    lit("ecall_state", 32'(state_o), 32'd5);
    lit("ecall_instret", instret, 32'd6);
    halt_idle(3);
    do_reset();
    run_instr(IMM, T - 1, 0, 1'b0, 1'b0, n);
    lit("late_ack_cycles", 32'(n), 32'(T + 3));
    lit("late_ack_bus_err", 32'(bus_err), 32'd0);
    run_instr(7'b0000000, 0, 0, 1'b0, 1'b0, n);
`ifdef ILLEGAL_TRAP_EN
    lit("illegal_flag", 32'(illegal), 32'd1);
    lit("illegal_state", 32'(state_o), 32'd5);
    halt_idle(2);
    do_reset();
`else
    lit("nop_instret", instret, 32'd2);
    lit("nop_state", 32'(state_o), 32'd0);
`endif
    run_instr(LD, 0, 5, 1'b0, 1'b1, n);
    lit("abort_instret", instret, 32'd0);
    lit("abort_state", 32'(state_o), 32'd0);
    run_instr(IMM, T + 4, 0, 1'b0, 1'b0, n);
    lit("timeout_cycles", 32'(n), 32'(T));
    lit("timeout_bus_err", 32'(bus_err), 32'd1);
    lit("timeout_state", 32'(state_o), 32'd5);
    halt_idle(3);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (m_halted) begin
        halt_idle(2);
        do_reset();
      end
      run_instr(pick(), delay(), delay(), 1'($urandom), $urandom_range(0, 39) == 0, n);
    end
    ex_valid = 1'b0;
    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
